// File: rtl/accum_pkg.sv
// ----------------------------------------------------------------------------
// accum_pkg
//
// Purpose:
//   Shared definitions for the sample accumulation stage: the datapath width
//   and the two-state control enum used by sample_accumulator.
//
// Contents:
//   DATA_WIDTH      - width of samples and of the running sum (16 bits)
//   accum_state_t   - ACCUM  : collecting samples, in_ready asserted
//                     RESULT : holding a finished result, out_valid asserted
// ----------------------------------------------------------------------------
package accum_pkg;

    localparam int DATA_WIDTH = 16;

    typedef enum logic {
        ACCUM  = 1'b0,
        RESULT = 1'b1
    } accum_state_t;

endpackage : accum_pkg

// File: rtl/adder_16bit.sv
// ----------------------------------------------------------------------------
// adder_16bit
//
// Purpose:
//   Purely combinational 16-bit unsigned adder. It is the only arithmetic
//   element in the accumulation datapath.
//
// Ports:
//   a        in  16 : first operand
//   b        in  16 : second operand
//   carry_in in   1 : carry into bit 0
//   sum      out 16 : (a + b + carry_in) mod 2^16
//   overflow out  1 : unsigned carry out of bit 15
// ----------------------------------------------------------------------------
module adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        carry_in,
    output logic [15:0] sum,
    output logic        overflow
);

    // A 17-bit result keeps the carry out; the top bit is the unsigned
    // overflow indication and the low 16 bits are the wrapped sum.
    logic [16:0] full_sum;

    always_comb begin
        full_sum = {1'b0, a} + {1'b0, b} + {16'd0, carry_in};
    end

    assign sum      = full_sum[15:0];
    assign overflow = full_sum[16];

endmodule : adder_16bit

// File: rtl/sample_accumulator.sv
// ----------------------------------------------------------------------------
// sample_accumulator
//
// Purpose:
//   Collects NUM_SAMPLES unsigned 16-bit samples over a valid/ready input
//   handshake, summing them through a single adder_16bit instance. The wrapped
//   sum and a sticky overflow flag are held in registers. Once the final
//   sample is accepted the result is presented on an output valid/ready
//   handshake and held until consumed.
//
// Parameters:
//   NUM_SAMPLES : samples per result, 1..65535
//   CNT_WIDTH   : width of the sample counter
//
// Ports:
//   clk          in  1         : system clock, rising edge
//   n_rst        in  1         : asynchronous active-low reset
//   clear        in  1         : synchronous abort of partial/held result
//   in_valid     in  1         : upstream sample present
//   in_data      in  16        : unsigned sample
//   in_ready     out 1         : sample can be accepted this cycle
//   out_valid    out 1         : result is being held
//   out_ready    in  1         : downstream consumes the result
//   out_sum      out 16        : accumulator register (wrapped sum)
//   out_overflow out 1         : sticky carry-out across the current result
//   sample_count out CNT_WIDTH : samples accepted toward the current result
// ----------------------------------------------------------------------------
module sample_accumulator
    import accum_pkg::*;
#(
    parameter int NUM_SAMPLES = 4,
    parameter int CNT_WIDTH   = $clog2(NUM_SAMPLES + 1)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_sum,
    output logic                  out_overflow,
    output logic [CNT_WIDTH-1:0]  sample_count
);

    // Registered state
    accum_state_t          state_q;
    logic [DATA_WIDTH-1:0] sum_q;
    logic                  ovf_q;
    logic [CNT_WIDTH-1:0]  count_q;

    // Next-state values
    accum_state_t          state_d;
    logic [DATA_WIDTH-1:0] sum_d;
    logic                  ovf_d;
    logic [CNT_WIDTH-1:0]  count_d;

    // Datapath and handshake qualifiers
    logic [DATA_WIDTH-1:0] adder_sum;
    logic                  adder_ovf;
    logic [CNT_WIDTH-1:0]  count_inc;
    logic                  accept;
    logic                  consume;
    logic                  last_sample;

    // The adder always sees the running total and the offered sample; its
    // result is only captured when a sample is actually accepted.
    adder_16bit u_adder (
        .a        (sum_q),
        .b        (in_data),
        .carry_in (1'b0),
        .sum      (adder_sum),
        .overflow (adder_ovf)
    );

    // Handshake outputs decode from state alone, so neither ready nor valid
    // has a combinational path from the opposite side of the interface.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == RESULT);

    assign accept      = in_valid && in_ready;
    assign consume     = out_valid && out_ready;
    assign count_inc   = count_q + CNT_WIDTH'(1);
    assign last_sample = (count_inc == CNT_WIDTH'(NUM_SAMPLES));

    assign out_sum      = sum_q;
    assign out_overflow = ovf_q;
    assign sample_count = count_q;

    // Next-state logic. Registers hold by default; clear overrides any
    // accept or consume in the same cycle, so a sample or result offered
    // alongside clear is treated as never transferred.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        count_d = count_q;

        if (clear) begin
            state_d = ACCUM;
            sum_d   = '0;
            ovf_d   = 1'b0;
            count_d = '0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (accept) begin
                        sum_d   = adder_sum;
                        ovf_d   = ovf_q | adder_ovf;
                        count_d = count_inc;
                        if (last_sample) begin
                            state_d = RESULT;
                        end
                    end
                end
                RESULT: begin
                    if (consume) begin
                        state_d = ACCUM;
                        sum_d   = '0;
                        ovf_d   = 1'b0;
                        count_d = '0;
                    end
                end
                default: begin
                    state_d = ACCUM;
                end
            endcase
        end
    end

    // State and accumulator registers; reset takes effect immediately and
    // discards any partial or held result.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ACCUM;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

endmodule : sample_accumulator

// File: tb/tb_sample_accumulator.sv
// ----------------------------------------------------------------------------
// tb_sample_accumulator
//
// Purpose:
//   Directed self-checking bench for sample_accumulator. The main instance
//   uses NUM_SAMPLES=4; a second instance with NUM_SAMPLES=1 shares the same
//   inputs to cover the single-sample case.
// ----------------------------------------------------------------------------
module tb_sample_accumulator;

    logic        clk;
    logic        n_rst;
    logic        clear;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_sum;
    logic        out_overflow;
    logic [2:0]  sample_count;

    logic        in_ready_1;
    logic        out_valid_1;
    logic [15:0] out_sum_1;
    logic        out_overflow_1;
    logic [0:0]  sample_count_1;

    int checks = 0;
    int errors = 0;

    sample_accumulator #(.NUM_SAMPLES(4)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_overflow (out_overflow),
        .sample_count (sample_count)
    );

    sample_accumulator #(.NUM_SAMPLES(1)) dut_one (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready_1),
        .out_valid    (out_valid_1),
        .out_ready    (out_ready),
        .out_sum      (out_sum_1),
        .out_overflow (out_overflow_1),
        .sample_count (sample_count_1)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, let one rising edge pass, then settle 1 ns
    // so outputs are sampled away from the edge.
    task automatic applyStimulus(input logic v, input logic [15:0] d,
                                 input logic rdy, input logic clr);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        clear     = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Check the full visible state of the main instance in one call.
    task automatic checkMain(input string tag, input logic exp_ir,
                             input logic exp_ov, input logic [15:0] exp_sum,
                             input logic exp_ovf, input logic [2:0] exp_cnt);
        checkOutput({tag, ".in_ready"},     {31'd0, in_ready},     {31'd0, exp_ir});
        checkOutput({tag, ".out_valid"},    {31'd0, out_valid},    {31'd0, exp_ov});
        checkOutput({tag, ".out_sum"},      {16'd0, out_sum},      {16'd0, exp_sum});
        checkOutput({tag, ".out_overflow"}, {31'd0, out_overflow}, {31'd0, exp_ovf});
        checkOutput({tag, ".sample_count"}, {29'd0, sample_count}, {29'd0, exp_cnt});
    endtask

    initial begin
        n_rst     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;

        // Reset state, observed while reset is held
        #12;
        checkMain("reset_held", 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0);
        @(negedge clk);
        n_rst = 1'b1;
        #1;
        checkMain("reset_released", 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0);

        // Basic sum: 1+2+3+4 = 0x000A
        applyStimulus(1'b1, 16'h0001, 1'b1, 1'b0);
        checkMain("basic_s1", 1'b1, 1'b0, 16'h0001, 1'b0, 3'd1);
        checkOutput("one.valid_s1", {31'd0, out_valid_1}, 32'd1);
        checkOutput("one.sum_s1",   {16'd0, out_sum_1},   32'h0001);
        checkOutput("one.ready_s1", {31'd0, in_ready_1},  32'd0);
        applyStimulus(1'b1, 16'h0002, 1'b1, 1'b0);
        checkMain("basic_s2", 1'b1, 1'b0, 16'h0003, 1'b0, 3'd2);
        checkOutput("one.valid_s2", {31'd0, out_valid_1}, 32'd0);
        checkOutput("one.sum_s2",   {16'd0, out_sum_1},   32'h0000);
        applyStimulus(1'b1, 16'h0003, 1'b1, 1'b0);
        checkMain("basic_s3", 1'b1, 1'b0, 16'h0006, 1'b0, 3'd3);
        checkOutput("one.sum_s3",   {16'd0, out_sum_1},   32'h0003);
        applyStimulus(1'b1, 16'h0004, 1'b1, 1'b0);
        checkMain("basic_result", 1'b0, 1'b1, 16'h000A, 1'b0, 3'd4);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkMain("basic_handoff", 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0);

        // Overflow and wrap: 0xFFFF + 2 wraps to 1, flag sticks through zeros
        applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b0);
        checkMain("ovf_s1", 1'b1, 1'b0, 16'hFFFF, 1'b0, 3'd1);
        applyStimulus(1'b1, 16'h0002, 1'b0, 1'b0);
        checkMain("ovf_s2", 1'b1, 1'b0, 16'h0001, 1'b1, 3'd2);
        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0);
        checkMain("ovf_result", 1'b0, 1'b1, 16'h0001, 1'b1, 3'd4);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkMain("ovf_handoff", 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0);
        checkMain("ovf_next", 1'b0, 1'b1, 16'h0004, 1'b0, 3'd4);

        // Output backpressure: held result ignores offered samples
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
            checkMain("backpressure", 1'b0, 1'b1, 16'h0004, 1'b0, 3'd4);
        end
        applyStimulus(1'b1, 16'h1234, 1'b1, 1'b0);
        checkMain("bp_handoff", 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0);
        applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
        checkMain("bp_first_accept", 1'b1, 1'b0, 16'h1234, 1'b0, 3'd1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        checkMain("bp_clear", 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0);

        // Input gaps: invalid cycles carry junk data that must not count
        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0);
        checkMain("gap_v1", 1'b1, 1'b0, 16'h0010, 1'b0, 3'd1);
        applyStimulus(1'b0, 16'hFFFF, 1'b0, 1'b0);
        checkMain("gap_i1", 1'b1, 1'b0, 16'h0010, 1'b0, 3'd1);
        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0);
        checkMain("gap_v2", 1'b1, 1'b0, 16'h0020, 1'b0, 3'd2);
        applyStimulus(1'b0, 16'hFFFF, 1'b0, 1'b0);
        checkMain("gap_i2", 1'b1, 1'b0, 16'h0020, 1'b0, 3'd2);
        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'hFFFF, 1'b0, 1'b0);
        checkMain("gap_i3", 1'b1, 1'b0, 16'h0030, 1'b0, 3'd3);
        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0);
        checkMain("gap_result", 1'b0, 1'b1, 16'h0040, 1'b0, 3'd4);

        // Clear while holding a result beats out_ready
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
        checkMain("clear_result", 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0);

        // Clear mid-accumulation drops the sample offered alongside it
        applyStimulus(1'b1, 16'h0100, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0200, 1'b0, 1'b0);
        checkMain("clear_pre", 1'b1, 1'b0, 16'h0300, 1'b0, 3'd2);
        applyStimulus(1'b1, 16'h0300, 1'b0, 1'b1);
        checkMain("clear_mid", 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0);
        checkMain("clear_after", 1'b0, 1'b1, 16'h0004, 1'b0, 3'd4);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

        // Async reset mid-RESULT, asserted between clock edges
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h0002, 1'b0, 1'b0);
        checkMain("rst_pre", 1'b0, 1'b1, 16'h0008, 1'b0, 3'd4);
        in_valid = 1'b0;
        #1;
        n_rst = 1'b0;
        #1;
        checkMain("rst_async", 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0);
        @(negedge clk);
        n_rst = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        checkMain("rst_after", 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule : tb_sample_accumulator
